// File: rtl/regfile_wb_arb.sv
// regfile_wb_arb
//   Write-back arbiter and pending-write scoreboard for the 16x16 register file.
//   NREQ producers share the single regfile write port by round-robin. The
//   granted write is registered onto wr_en/wr_addr/wr_data one cycle later.
//   Register PC_ADDR is the read-only PC view. A write to it is consumed, never
//   reaches the regfile, and sets the sticky pc_wr_err flag.
//
// Ports
//   clk        in   system clock, all state on rising edge
//   reset_n    in   asynchronous active-low reset
//   req_valid  in   [NREQ]         per-requester write pending
//   req_addr   in   [NREQ*ADDR_W]  destination register, slice i
//   req_data   in   [NREQ*DATA_W]  write data, slice i
//   req_ready  out  [NREQ]         one-hot grant (transfer on valid & ready)
//   rsv_valid  in   issue stage reserves rsv_addr
//   rsv_addr   in   [ADDR_W]       register being reserved
//   err_clr    in   clears pc_wr_err
//   wr_en      out  registered regfile write enable
//   wr_addr    out  [ADDR_W]       registered regfile write address
//   wr_data    out  [DATA_W]       registered regfile write data
//   busy       out  [2**ADDR_W]    bit r set while a write to r is outstanding
//   pc_wr_err  out  sticky: a write to PC_ADDR was absorbed
module regfile_wb_arb #(
  parameter int unsigned NREQ    = 3,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned PC_ADDR = 15
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     rsv_valid,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic                     err_clr,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  output logic [(2**ADDR_W)-1:0]   busy,
  output logic                     pc_wr_err
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NREG  = 2 ** ADDR_W;

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              pc_err_q, pc_err_d;

  logic              hi_found, lo_found, gnt_any, gnt_pc;
  logic [PTR_W-1:0]  hi_idx, lo_idx, gidx;
  logic [ADDR_W-1:0] gaddr;
  logic [DATA_W-1:0] gdata;

  // Round-robin pick: the lowest valid index at/after ptr wins; failing that,
  // the lowest valid index overall (the wrap-around case).
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req_valid[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = PTR_W'(i);
      end
      if (req_valid[i] && !hi_found && (PTR_W'(i) >= ptr_q)) begin
        hi_found = 1'b1;
        hi_idx   = PTR_W'(i);
      end
    end
    gidx    = hi_found ? hi_idx : lo_idx;
    // Gating with reset_n keeps ready low for the whole reset, not just after an edge.
    gnt_any = (hi_found | lo_found) & reset_n;
    gaddr   = req_addr[gidx*ADDR_W +: ADDR_W];
    gdata   = req_data[gidx*DATA_W +: DATA_W];
    gnt_pc  = gnt_any && (gaddr == ADDR_W'(PC_ADDR));
    req_ready = '0;
    if (gnt_any) req_ready[gidx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) ptr_d = (gidx == PTR_W'(NREQ - 1)) ? '0 : gidx + PTR_W'(1);

    // PC writes are consumed but never reach the regfile; address/data hold.
    wr_en_d   = gnt_any & ~gnt_pc;
    wr_addr_d = wr_en_d ? gaddr : wr_addr_q;
    wr_data_d = wr_en_d ? gdata : wr_data_q;

    // A new PC write in the same cycle as err_clr keeps the flag set.
    pc_err_d = pc_err_q;
    if (err_clr) pc_err_d = 1'b0;
    if (gnt_pc)  pc_err_d = 1'b1;

    // Clear first, then set, so a same-cycle reserve of the written register wins.
    busy_d = busy_q;
    if (wr_en_q) busy_d[wr_addr_q] = 1'b0;
    if (rsv_valid && (rsv_addr != ADDR_W'(PC_ADDR))) busy_d[rsv_addr] = 1'b1;
    busy_d[PC_ADDR] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= '0;
      pc_err_q  <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      pc_err_q  <= pc_err_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign pc_wr_err = pc_err_q;

endmodule

// File: tb/tb_regfile_wb_arb.sv
// tb_regfile_wb_arb
//   Directed bench for regfile_wb_arb. Each accepted grant pushes the write the
//   regfile should see onto a queue; a monitor on the falling edge pops and
//   compares whenever wr_en is presented.
module tb_regfile_wb_arb;

  typedef struct packed {
    logic [3:0]  a;
    logic [15:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  req_valid;
  logic [11:0] req_addr;
  logic [47:0] req_data;
  logic [2:0]  req_ready;
  logic        rsv_valid;
  logic [3:0]  rsv_addr;
  logic        err_clr;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [15:0] busy;
  logic        pc_wr_err;

  wr_t exp_q[$];
  wr_t mon_e;
  int  errors = 0;
  int  checks = 0;

  always #5 clk = ~clk;

  regfile_wb_arb #(.NREQ(3), .DATA_W(16), .ADDR_W(4), .PC_ADDR(15)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .err_clr(err_clr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .pc_wr_err(pc_wr_err)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic wr_t mk(input logic [3:0] a, input logic [15:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    return w;
  endfunction

  // Write monitor: every presented write must match the oldest expected one.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_unexpected: got write addr=%0h data=%0h expected none", wr_addr, wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(mon_e.a));
        chk("wr_data", 32'(wr_data), 32'(mon_e.d));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setreq(input int i, input logic v, input logic [3:0] a, input logic [15:0] d);
    req_valid[i]         = v;
    req_addr[i*4 +: 4]   = a;
    req_data[i*16 +: 16] = d;
  endtask

  task automatic expect_grant(input string name, input logic [2:0] r, input logic push, input wr_t w);
    @(negedge clk);
    chk(name, 32'(req_ready), 32'(r));
    if (push) exp_q.push_back(w);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    req_valid = 3'b111;
    req_addr  = {4'd4, 4'd2, 4'd1};
    req_data  = '0;
    rsv_valid = 1'b0;
    rsv_addr  = '0;
    err_clr   = 1'b0;
    #22;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pc_err", 32'(pc_wr_err), 32'd0);
    req_valid = '0;
    tick();
    reset_n = 1'b1;

    // 1: reserve r3, write BEEF to r3, reservation clears after the write
    rsv_valid = 1'b1; rsv_addr = 4'd3;
    tick();
    rsv_valid = 1'b0;
    setreq(0, 1'b1, 4'd3, 16'hBEEF);
    expect_grant("t1_ready", 3'b001, 1'b1, mk(4'd3, 16'hBEEF));
    chk("t1_busy3_set", 32'(busy[3]), 32'd1);
    tick();
    setreq(0, 1'b0, 4'd0, 16'h0);
    @(negedge clk);
    chk("t1_wr_en", 32'(wr_en), 32'd1);
    chk("t1_busy3_inflight", 32'(busy[3]), 32'd1);
    tick();
    @(negedge clk);
    chk("t1_busy3_clr", 32'(busy[3]), 32'd0);
    chk("t1_wr_en_idle", 32'(wr_en), 32'd0);

    // fresh pointer for the rotation test
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;

    // 2: all three held valid -> 0,1,2,0,1,2 back-to-back
    setreq(0, 1'b1, 4'd1, 16'h1111);
    setreq(1, 1'b1, 4'd2, 16'h2222);
    setreq(2, 1'b1, 4'd4, 16'h4444);
    for (int k = 0; k < 6; k++) begin
      logic [2:0] r;
      wr_t w;
      r = 3'(1 << (k % 3));
      w = (k % 3 == 0) ? mk(4'd1, 16'h1111) : (k % 3 == 1) ? mk(4'd2, 16'h2222) : mk(4'd4, 16'h4444);
      expect_grant("t2_grant", r, 1'b1, w);
      if (k > 0) chk("t2_wr_en", 32'(wr_en), 32'd1);
      tick();
    end
    req_valid = '0;
    @(negedge clk);
    chk("t2_wr_en_last", 32'(wr_en), 32'd1);
    tick();
    @(negedge clk);
    chk("t2_wr_en_off", 32'(wr_en), 32'd0);

    // 3: PC write absorbed, flag sticky, clear vs simultaneous PC write
    tick();
    setreq(1, 1'b1, 4'd15, 16'h1234);
    expect_grant("t3_ready", 3'b010, 1'b0, mk(4'd0, 16'h0));
    tick();
    setreq(1, 1'b0, 4'd0, 16'h0);
    @(negedge clk);
    chk("t3_wr_en", 32'(wr_en), 32'd0);
    chk("t3_pc_err", 32'(pc_wr_err), 32'd1);
    tick();
    @(negedge clk);
    chk("t3_pc_err_sticky", 32'(pc_wr_err), 32'd1);
    tick();
    err_clr = 1'b1;
    setreq(2, 1'b1, 4'd15, 16'h0F0F);
    expect_grant("t3_ready2", 3'b100, 1'b0, mk(4'd0, 16'h0));
    tick();
    setreq(2, 1'b0, 4'd0, 16'h0);
    @(negedge clk);
    chk("t3_pc_err_setwins", 32'(pc_wr_err), 32'd1);
    chk("t3_wr_en2", 32'(wr_en), 32'd0);
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    chk("t3_pc_err_clr", 32'(pc_wr_err), 32'd0);

    // 4: reserve same register as a completing write -> stays busy; PC reserve ignored
    tick();
    rsv_valid = 1'b1; rsv_addr = 4'd5;
    setreq(0, 1'b1, 4'd5, 16'h5A5A);
    expect_grant("t4_ready", 3'b001, 1'b1, mk(4'd5, 16'h5A5A));
    tick();
    setreq(0, 1'b0, 4'd0, 16'h0);
    @(negedge clk);
    chk("t4_busy5_set", 32'(busy[5]), 32'd1);
    tick();
    rsv_addr = 4'd15;
    @(negedge clk);
    chk("t4_busy5_setwins", 32'(busy[5]), 32'd1);
    tick();
    rsv_valid = 1'b0;
    @(negedge clk);
    chk("t4_busy15", 32'(busy[15]), 32'd0);
    chk("t4_busy_all", 32'(busy), 32'h0020);

    // 5: wrap to req0, then lone req2 immediately, then pointer back at 0
    tick();
    setreq(0, 1'b1, 4'd7, 16'h7777);
    expect_grant("t5_wrap0", 3'b001, 1'b1, mk(4'd7, 16'h7777));
    tick();
    setreq(0, 1'b0, 4'd0, 16'h0);
    setreq(2, 1'b1, 4'd6, 16'h6666);
    expect_grant("t5_req2", 3'b100, 1'b1, mk(4'd6, 16'h6666));
    chk("t5_wr_en_a", 32'(wr_en), 32'd1);
    tick();
    setreq(0, 1'b1, 4'd8, 16'h8888);
    setreq(1, 1'b1, 4'd9, 16'h9999);
    setreq(2, 1'b1, 4'd10, 16'hAAAA);
    expect_grant("t5_ptr0", 3'b001, 1'b1, mk(4'd8, 16'h8888));
    chk("t5_wr_en_b", 32'(wr_en), 32'd1);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("t5_wr_en_c", 32'(wr_en), 32'd1);

    // 6: async reset while a write is on the port
    tick();
    setreq(1, 1'b1, 4'd11, 16'hBBBB);
    rsv_valid = 1'b1; rsv_addr = 4'd12;
    expect_grant("t6_ready", 3'b010, 1'b1, mk(4'd11, 16'hBBBB));
    tick();
    setreq(1, 1'b0, 4'd0, 16'h0);
    rsv_valid = 1'b0;
    setreq(0, 1'b1, 4'd13, 16'hDDDD);
    #2;
    chk("t6_pre_wr_en", 32'(wr_en), 32'd1);
    chk("t6_pre_busy12", 32'(busy[12]), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_wr_en", 32'(wr_en), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_ready", 32'(req_ready), 32'd0);
    exp_q.delete();
    tick();
    reset_n = 1'b1;
    setreq(1, 1'b1, 4'd14, 16'hEEEE);
    expect_grant("t6_ptr_reset", 3'b001, 1'b1, mk(4'd13, 16'hDDDD));
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("t6_wr_en_after", 32'(wr_en), 32'd1);
    tick();
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
